// File: rtl/pulse_period_meter.sv
// pulse_period_meter
//
// Measures the number of clk cycles between consecutive single-cycle strobes
// on pulse_in and offers each completed interval on a valid/ready port. It
// also flags intervals that run past the counter range (timeout), samples
// thrown away because the consumer was not ready (overrun), and a run of
// identical periods (locked).
//
// Ports:
//   clk           system clock, all state changes on its rising edge
//   rst           asynchronous active-low reset
//   ena           measurement enable; low forces the measurer back to idle
//   pulse_in      strobe input, every high cycle is one pulse event
//   period        last accepted interval in cycles (N bits)
//   period_valid  period holds a sample the consumer has not taken yet
//   period_ready  consumer takes the sample when period_valid is also high
//   timeout       one-cycle flag: no pulse arrived within 2^N-1 cycles
//   overrun       one-cycle flag: a new sample was dropped due to backpressure
//   locked        the last LOCK_COUNT samples were all equal
module pulse_period_meter #(
    parameter int N          = 8,
    parameter int LOCK_COUNT = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic         pulse_in,
    output logic [N-1:0] period,
    output logic         period_valid,
    input  logic         period_ready,
    output logic         timeout,
    output logic         overrun,
    output logic         locked
);

    typedef enum logic {
        IDLE,
        MEASURE
    } state_t;

    localparam logic [N-1:0] COUNT_MAX = '1;
    localparam logic [N-1:0] COUNT_ONE = N'(1);
    localparam logic [3:0]   LOCK_MAX  = 4'(LOCK_COUNT - 1);

    state_t       state;
    state_t       state_next;
    logic [N-1:0] count;
    logic [N-1:0] count_next;
    logic [N-1:0] last_sample;
    logic [N-1:0] last_sample_next;
    logic [N-1:0] period_next;
    logic [3:0]   lock_cnt;
    logic [3:0]   lock_cnt_next;
    logic         period_valid_next;
    logic         timeout_next;
    logic         overrun_next;
    logic         locked_next;
    logic         sample_fire;

    // State register for the measurer, the output slot and the lock tracker.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            count        <= '0;
            last_sample  <= '0;
            lock_cnt     <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            timeout      <= 1'b0;
            overrun      <= 1'b0;
            locked       <= 1'b0;
        end else begin
            state        <= state_next;
            count        <= count_next;
            last_sample  <= last_sample_next;
            lock_cnt     <= lock_cnt_next;
            period       <= period_next;
            period_valid <= period_valid_next;
            timeout      <= timeout_next;
            overrun      <= overrun_next;
            locked       <= locked_next;
        end
    end

    // Next-state logic. Whenever the measurer returns to IDLE the remembered
    // sample is cleared to zero; a real sample is never zero, so the first
    // sample of a new run always mismatches and merely seeds the history.
    always_comb begin
        state_next        = state;
        count_next        = count;
        last_sample_next  = last_sample;
        lock_cnt_next     = lock_cnt;
        period_next       = period;
        period_valid_next = period_valid;
        timeout_next      = 1'b0;
        overrun_next      = 1'b0;
        sample_fire       = 1'b0;

        if (!ena) begin
            state_next       = IDLE;
            count_next       = '0;
            lock_cnt_next    = '0;
            last_sample_next = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pulse_in) begin
                        state_next = MEASURE;
                        count_next = COUNT_ONE;
                    end
                end
                MEASURE: begin
                    if (pulse_in) begin
                        // A pulse on the last counter value is still a
                        // valid sample of the maximum period.
                        sample_fire = 1'b1;
                        count_next  = COUNT_ONE;
                    end else if (count == COUNT_MAX) begin
                        timeout_next     = 1'b1;
                        state_next       = IDLE;
                        count_next       = '0;
                        lock_cnt_next    = '0;
                        last_sample_next = '0;
                    end else begin
                        count_next = count + COUNT_ONE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end

        // Lock tracking sees every sample, even those later dropped.
        if (sample_fire) begin
            if (count == last_sample) begin
                lock_cnt_next = (lock_cnt == LOCK_MAX) ? lock_cnt : lock_cnt + 4'd1;
            end else begin
                lock_cnt_next = '0;
            end
            last_sample_next = count;

            if (!period_valid || period_ready) begin
                period_next       = count;
                period_valid_next = 1'b1;
            end else begin
                overrun_next = 1'b1;
            end
        end else if (period_valid && period_ready) begin
            period_valid_next = 1'b0;
        end

        locked_next = (lock_cnt_next == LOCK_MAX);
    end

endmodule
